sc_down_counter: RTL



---
 rtl/sc_counter_pkg.sv | 20 ++
 rtl/sc_down_counter_if.sv | 42 ++++
 rtl/sc_fall_edge_detect.sv | 35 +++
 rtl/sc_down_counter.sv | 92 +++++++++
 4 files changed

// File: rtl/sc_counter_pkg.sv
// Shared definitions for the score/lives counters: counter state encoding,
// default geometry, and a helper that maps a count onto its state.
package sc_counter_pkg;

  // Default counter width and reset value for the down counter.
  localparam int SC_DEFAULT_WIDTH      = 2;
  localparam int SC_DEFAULT_INIT_VALUE = 3;

  // RUN while the count is non-zero, EMPTY while it sits at zero.
  typedef enum logic {
    RUN   = 1'b0,
    EMPTY = 1'b1
  } sc_state_e;

  // State that corresponds to a freshly loaded value.
  function automatic sc_state_e sc_state_for(input logic is_zero);
    return is_zero ? EMPTY : RUN;
  endfunction

endpackage

// File: rtl/sc_down_counter_if.sv
// Signal bundle of the down counter. The master side (game FSM or bench)
// drives load/data/downcount; the slave side (the counter) returns the count,
// zero/expired flags and its FSM state for observation.
//
// There is no valid/ready handshake on this block: every input is sampled on
// each rising clock edge, and every output is a registered level that is
// valid from one edge to the next.
interface sc_down_counter_if
  import sc_counter_pkg::*;
#(
  parameter int WIDTH = SC_DEFAULT_WIDTH
);

  logic             SC_downCOUNTER_load_InLow;
  logic [WIDTH-1:0] SC_downCOUNTER_data_InBUS;
  logic             SC_downCOUNTER_downcount_InLow;
  logic [WIDTH-1:0] SC_downCOUNTER_data_OutBUS;
  logic             SC_downCOUNTER_zero_OutHigh;
  logic             SC_downCOUNTER_expired_OutHigh;
  sc_state_e        state_dbg;

  modport master (
    output SC_downCOUNTER_load_InLow,
    output SC_downCOUNTER_data_InBUS,
    output SC_downCOUNTER_downcount_InLow,
    input  SC_downCOUNTER_data_OutBUS,
    input  SC_downCOUNTER_zero_OutHigh,
    input  SC_downCOUNTER_expired_OutHigh,
    input  state_dbg
  );

  modport slave (
    input  SC_downCOUNTER_load_InLow,
    input  SC_downCOUNTER_data_InBUS,
    input  SC_downCOUNTER_downcount_InLow,
    output SC_downCOUNTER_data_OutBUS,
    output SC_downCOUNTER_zero_OutHigh,
    output SC_downCOUNTER_expired_OutHigh,
    output state_dbg
  );

endinterface

// File: rtl/sc_fall_edge_detect.sv
// Falling-edge detector for an active-low, already-synchronous button level.
// Produces a single-cycle pulse for each high-to-low transition of din.
//
// history_q resets to 1 (deasserted). armed_q resets to 0 and sets once din
// has been sampled high, so a level that is already low when reset releases
// is not taken as a new press; the first counted edge needs a return high.
module sc_fall_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall
);

  logic history_q, history_d;
  logic armed_q, armed_d;

  // Next-state of the history and arming flops, plus the edge pulse.
  always_comb begin
    history_d = din;
    armed_d   = armed_q | din;
    fall      = armed_q & history_q & ~din;
  end

  // History and arming registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history_q <= 1'b1;
      armed_q   <= 1'b0;
    end else begin
      history_q <= history_d;
      armed_q   <= armed_d;
    end
  end

endmodule

// File: rtl/sc_down_counter.sv
// Loadable down counter for lives/countdown indicators.
// One decrement per active-low downcount episode; load (active-low) has
// priority over a decrement. zero_OutHigh follows the EMPTY state and
// expired_OutHigh pulses for the first cycle the count reads zero after a
// decrement.
//
// Build option SC_DOWNCOUNTER_WRAP_EN: a decrement while EMPTY wraps the
// count to all-ones, returns to RUN and pulses expired as an underflow flag.
// Without it the counter saturates at zero and ignores such decrements.
//
// WIDTH is legal from 1 to 8; INIT_VALUE must fit in WIDTH bits.
module sc_down_counter
  import sc_counter_pkg::*;
#(
  parameter int WIDTH      = SC_DEFAULT_WIDTH,
  parameter int INIT_VALUE = SC_DEFAULT_INIT_VALUE
) (
  input  logic               SC_downCOUNTER_CLOCK_50,
  input  logic               SC_downCOUNTER_RESET_InHigh,
  sc_down_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] INIT_CNT   = WIDTH'(INIT_VALUE);
  localparam sc_state_e        INIT_STATE = (INIT_VALUE == 0) ? EMPTY : RUN;

  logic             dec_req;
  logic [WIDTH-1:0] count_q, count_d;
  sc_state_e        state_q, state_d;
  logic             expired_q, expired_d;

  sc_fall_edge_detect u_fall_edge_detect (
    .clk  (SC_downCOUNTER_CLOCK_50),
    .rst  (SC_downCOUNTER_RESET_InHigh),
    .din  (bus.SC_downCOUNTER_downcount_InLow),
    .fall (dec_req)
  );

  // Next count/state/pulse: load beats decrement; expiry only by decrement.
  always_comb begin
    count_d   = count_q;
    state_d   = state_q;
    expired_d = 1'b0;
    if (!bus.SC_downCOUNTER_load_InLow) begin
      count_d = bus.SC_downCOUNTER_data_InBUS;
      state_d = sc_state_for(bus.SC_downCOUNTER_data_InBUS == '0);
    end else if (dec_req) begin
      case (state_q)
        RUN: begin
          if (count_q == WIDTH'(1)) begin
            count_d   = '0;
            state_d   = EMPTY;
            expired_d = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        EMPTY: begin
`ifdef SC_DOWNCOUNTER_WRAP_EN
          count_d   = '1;
          state_d   = RUN;
          expired_d = 1'b1;
`else
          count_d   = '0;
`endif
        end
        default: begin
          count_d = count_q;
          state_d = state_q;
        end
      endcase
    end
  end

  // Counter FSM registers with registered outputs.
  always_ff @(posedge SC_downCOUNTER_CLOCK_50 or posedge SC_downCOUNTER_RESET_InHigh) begin
    if (SC_downCOUNTER_RESET_InHigh) begin
      count_q   <= INIT_CNT;
      state_q   <= INIT_STATE;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      state_q   <= state_d;
      expired_q <= expired_d;
    end
  end

  assign bus.SC_downCOUNTER_data_OutBUS     = count_q;
  assign bus.SC_downCOUNTER_zero_OutHigh    = (state_q == EMPTY);
  assign bus.SC_downCOUNTER_expired_OutHigh = expired_q;
  assign bus.state_dbg                      = state_q;

endmodule
